// File: rtl/mem_wb_latch_pkg.sv
// rtl/mem_wb_latch_pkg.sv - shared processor constants for the MEM/WB stage
package mem_wb_latch_pkg;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_JAL  = 5'b00011;

    localparam logic [4:0] LINK_REG = 5'd31;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RD_HI  = 26;
    localparam int RD_LO  = 22;

    function automatic logic [4:0] get_opcode(input logic [31:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [4:0] get_rd(input logic [31:0] instr);
        return instr[RD_HI:RD_LO];
    endfunction

endpackage

// File: rtl/mem_wb_latch_if.sv
// rtl/mem_wb_latch_if.sv - MEM/WB stage bus between pipeline control and latch
interface mem_wb_latch_if #(
    parameter int RETIRE_W = 32
);
    logic                i_stall;
    logic                i_flush;
    logic                i_valid_in;
    logic [31:0]         i_instruction_in;
    logic [31:0]         i_alu_result_in;
    logic [31:0]         i_mem_data_in;
    logic [31:0]         i_pc_plus_one_in;
    logic [31:0]         o_instruction_out;
    logic                o_valid_out;
    logic                o_wb_enable;
    logic [4:0]          o_wb_dest;
    logic [31:0]         o_wb_data;
    logic [RETIRE_W-1:0] o_retire_count;

    modport master (
        output i_stall, i_flush, i_valid_in, i_instruction_in,
               i_alu_result_in, i_mem_data_in, i_pc_plus_one_in,
        input  o_instruction_out, o_valid_out, o_wb_enable, o_wb_dest,
               o_wb_data, o_retire_count
    );

    modport slave (
        input  i_stall, i_flush, i_valid_in, i_instruction_in,
               i_alu_result_in, i_mem_data_in, i_pc_plus_one_in,
        output o_instruction_out, o_valid_out, o_wb_enable, o_wb_dest,
               o_wb_data, o_retire_count
    );
endinterface

// File: rtl/mem_wb_latch_wb_decode.sv
// rtl/mem_wb_latch_wb_decode.sv - write-back opcode classification
module wb_decode
    import mem_wb_latch_pkg::*;
(
    input  logic [31:0] i_instruction,
    output logic        o_is_write,
    output logic        o_is_lw,
    output logic        o_is_jal
);
    logic [4:0] w_opcode;

    assign w_opcode = get_opcode(i_instruction);

    always_comb begin
        o_is_write = 1'b0;
        o_is_lw    = 1'b0;
        o_is_jal   = 1'b0;
        case (w_opcode)
            OP_ALU, OP_ADDI: o_is_write = 1'b1;
            OP_LW: begin
                o_is_write = 1'b1;
                o_is_lw    = 1'b1;
            end
            OP_JAL: begin
                o_is_write = 1'b1;
                o_is_jal   = 1'b1;
            end
            default: o_is_write = 1'b0;
        endcase
    end
endmodule

// File: rtl/mem_wb_latch.sv
// rtl/mem_wb_latch.sv - MEM/WB pipeline register with write-back decode and retire counter
module mem_wb_latch
    import mem_wb_latch_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    mem_wb_latch_if.slave   bus
);
    logic [31:0]         r_instr;
    logic                r_valid;
    logic [31:0]         r_alu_result;
    logic [31:0]         r_mem_data;
    logic [31:0]         r_pc_plus_one;
    logic [RETIRE_W-1:0] r_retire;

    logic       w_is_write;
    logic       w_is_lw;
    logic       w_is_jal;
    logic [4:0] w_dest;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_instr       <= 32'h0;
            r_valid       <= 1'b0;
            r_alu_result  <= 32'h0;
            r_mem_data    <= 32'h0;
            r_pc_plus_one <= 32'h0;
            r_retire      <= '0;
        end else begin
            // Retirement is judged on the outgoing contents, so a flush still counts it.
            if (r_valid && !bus.i_stall) begin
                r_retire <= r_retire + 1'b1;
            end
            if (bus.i_flush) begin
                r_instr <= 32'h0;
                r_valid <= 1'b0;
            end else if (!bus.i_stall) begin
                r_instr       <= bus.i_instruction_in;
                r_valid       <= bus.i_valid_in;
                r_alu_result  <= bus.i_alu_result_in;
                r_mem_data    <= bus.i_mem_data_in;
                r_pc_plus_one <= bus.i_pc_plus_one_in;
            end
        end
    end

    wb_decode u_wb_decode (
        .i_instruction (r_instr),
        .o_is_write    (w_is_write),
        .o_is_lw       (w_is_lw),
        .o_is_jal      (w_is_jal)
    );

    assign w_dest = w_is_jal ? LINK_REG : get_rd(r_instr);

    assign bus.o_instruction_out = r_instr;
    assign bus.o_valid_out       = r_valid;
    assign bus.o_wb_dest         = w_dest;
    assign bus.o_wb_enable       = r_valid && w_is_write && (w_dest != 5'd0);
    assign bus.o_wb_data         = w_is_lw  ? r_mem_data :
                                   w_is_jal ? r_pc_plus_one : r_alu_result;
    assign bus.o_retire_count    = r_retire;
endmodule

// File: tb/tb_mem_wb_latch.sv
// tb/tb_mem_wb_latch.sv - directed vector bench for mem_wb_latch
module tb_mem_wb_latch;
    import mem_wb_latch_pkg::*;

    localparam int RW = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mem_wb_latch_if #(.RETIRE_W(RW)) bus ();

    mem_wb_latch #(.RETIRE_W(RW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic        exp_en;
        logic [4:0]  exp_dest;
        logic [31:0] exp_data;
        logic        chk_data;
        logic [3:0]  exp_ret;
    } vec_t;

    vec_t tbl [13];

    function automatic logic [31:0] mk(input logic [4:0] opc, input logic [4:0] rd);
        return {opc, rd, 22'h2a5a5};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {31'h0, bus.o_valid_out}, 32'h0);
        chk({tag, "_instr"}, bus.o_instruction_out, 32'h0);
        chk({tag, "_en"},    {31'h0, bus.o_wb_enable}, 32'h0);
        chk({tag, "_dest"},  {27'h0, bus.o_wb_dest}, 32'h0);
        chk({tag, "_data"},  bus.o_wb_data, 32'h0);
        chk({tag, "_ret"},   {28'h0, bus.o_retire_count}, 32'h0);
    endtask

    task automatic drive(input logic st, input logic fl, input logic v, input logic [31:0] ins,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc);
        bus.i_stall          = st;
        bus.i_flush          = fl;
        bus.i_valid_in       = v;
        bus.i_instruction_in = ins;
        bus.i_alu_result_in  = alu;
        bus.i_mem_data_in    = mem;
        bus.i_pc_plus_one_in = pc;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 1'b0, 1'b1, mk(OP_ADDI, 5'd9), 32'h11, 32'h22, 32'h33);

        // stall, flush, valid, instr, alu, mem, pc | valid, instr, en, dest, data, chk_data, retire
        tbl[0]  = '{1'b0, 1'b0, 1'b1, mk(OP_ADDI, 5'd5), 32'h7, 32'h0, 32'h0,
                    1'b1, mk(OP_ADDI, 5'd5), 1'b1, 5'd5, 32'h7, 1'b1, 4'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, mk(OP_LW, 5'd3), 32'h10, 32'hDEAD_BEEF, 32'h5,
                    1'b1, mk(OP_LW, 5'd3), 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1, 4'd1};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, mk(OP_JAL, 5'd7), 32'h99, 32'h88, 32'h40,
                    1'b1, mk(OP_JAL, 5'd7), 1'b1, 5'd31, 32'h40, 1'b1, 4'd2};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, mk(OP_ALU, 5'd0), 32'h55, 32'h1, 32'h2,
                    1'b1, mk(OP_ALU, 5'd0), 1'b0, 5'd0, 32'h55, 1'b1, 4'd3};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, mk(5'b00111, 5'd4), 32'h99, 32'h3, 32'h4,
                    1'b1, mk(5'b00111, 5'd4), 1'b0, 5'd4, 32'h99, 1'b1, 4'd4};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, mk(OP_ADDI, 5'd6), 32'h1, 32'h0, 32'h0,
                    1'b0, mk(OP_ADDI, 5'd6), 1'b0, 5'd6, 32'h1, 1'b1, 4'd5};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, mk(OP_ADDI, 5'd2), 32'h22, 32'h0, 32'h0,
                    1'b1, mk(OP_ADDI, 5'd2), 1'b1, 5'd2, 32'h22, 1'b1, 4'd5};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, mk(OP_LW, 5'd9), 32'h123, 32'h456, 32'h789,
                    1'b1, mk(OP_ADDI, 5'd2), 1'b1, 5'd2, 32'h22, 1'b1, 4'd5};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, mk(OP_JAL, 5'd1), 32'hAAA, 32'hBBB, 32'hCCC,
                    1'b1, mk(OP_ADDI, 5'd2), 1'b1, 5'd2, 32'h22, 1'b1, 4'd5};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, mk(OP_ALU, 5'd12), 32'hF0F0, 32'h0F0F, 32'h1,
                    1'b1, mk(OP_ADDI, 5'd2), 1'b1, 5'd2, 32'h22, 1'b1, 4'd5};
        tbl[10] = '{1'b1, 1'b1, 1'b1, mk(OP_LW, 5'd8), 32'h5, 32'h6, 32'h7,
                    1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 4'd5};
        tbl[11] = '{1'b0, 1'b0, 1'b1, mk(OP_ADDI, 5'd2), 32'h1, 32'h0, 32'h0,
                    1'b1, mk(OP_ADDI, 5'd2), 1'b1, 5'd2, 32'h1, 1'b1, 4'd5};
        tbl[12] = '{1'b0, 1'b1, 1'b1, mk(OP_LW, 5'd4), 32'h2, 32'h3, 32'h4,
                    1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 4'd6};

        // Reset state, held across a few clock edges with live inputs.
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].stall, tbl[i].flush, tbl[i].valid, tbl[i].instr,
                  tbl[i].alu, tbl[i].mem, tbl[i].pc);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), {31'h0, bus.o_valid_out}, {31'h0, tbl[i].exp_valid});
            chk($sformatf("v%0d_instr", i), bus.o_instruction_out, tbl[i].exp_instr);
            chk($sformatf("v%0d_en", i), {31'h0, bus.o_wb_enable}, {31'h0, tbl[i].exp_en});
            chk($sformatf("v%0d_dest", i), {27'h0, bus.o_wb_dest}, {27'h0, tbl[i].exp_dest});
            if (tbl[i].chk_data)
                chk($sformatf("v%0d_data", i), bus.o_wb_data, tbl[i].exp_data);
            chk($sformatf("v%0d_ret", i), {28'h0, bus.o_retire_count}, {28'h0, tbl[i].exp_ret});
        end

        // Counter wrap: retire count is 6 with valid_out low after the flush above.
        drive(1'b0, 1'b0, 1'b1, mk(OP_ADDI, 5'd1), 32'h3, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk("wrap_start", {28'h0, bus.o_retire_count}, 32'd6);
        repeat (9) @(posedge clk);
        #1;
        chk("wrap_full", {28'h0, bus.o_retire_count}, 32'd15);
        @(posedge clk);
        #1;
        chk("wrap_zero", {28'h0, bus.o_retire_count}, 32'd0);
        @(posedge clk);
        #1;
        chk("wrap_one", {28'h0, bus.o_retire_count}, 32'd1);
        chk("pre_rst_data", bus.o_wb_data, 32'h3);

        // Asynchronous reset mid-cycle while stall and flush are both up.
        drive(1'b1, 1'b1, 1'b1, mk(OP_JAL, 5'd3), 32'h9, 32'h9, 32'h9);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");

        // First load after reset release lands on the very next edge.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, mk(OP_ADDI, 5'd5), 32'h7, 32'h0, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_pre_valid", {31'h0, bus.o_valid_out}, 32'h0);
        @(posedge clk);
        #1;
        chk("rel_valid", {31'h0, bus.o_valid_out}, 32'h1);
        chk("rel_en", {31'h0, bus.o_wb_enable}, 32'h1);
        chk("rel_dest", {27'h0, bus.o_wb_dest}, 32'd5);
        chk("rel_data", bus.o_wb_data, 32'h7);
        chk("rel_ret0", {28'h0, bus.o_retire_count}, 32'd0);
        @(posedge clk);
        #1;
        chk("rel_ret1", {28'h0, bus.o_retire_count}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_wb_latch.md
MEM_WB_LATCH -- requirements
Module: mem_wb_latch

Interface
REQ-001 Parameter: RETIRE_W, default 32, width of the retired-instruction counter.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  hold all latched state this cycle.
REQ-005 flush  input  1  replace latched contents with a bubble this cycle.
REQ-006 valid_in  input  1  memory stage presents a real instruction.
REQ-007 instruction_in  input  32  memory-stage instruction word; opcode in [31:27], rd in [26:22].
REQ-008 alu_result_in  input  32  ALU result carried from execute.
REQ-009 mem_data_in  input  32  data-memory read data.
REQ-010 pc_plus_one_in  input  32  PC+1 of the instruction.
REQ-011 instruction_out  output  32  latched instruction word.
REQ-012 valid_out  output  1  latched instruction is real.
REQ-013 wb_enable  output  1  register-file write enable.
REQ-014 wb_dest  output  5  register-file write address.
REQ-015 wb_data  output  32  register-file write data.
REQ-016 retire_count  output  RETIRE_W  number of instructions retired since reset.

Function
REQ-017 Update priority each rising edge, highest first: reset, flush, stall, load.
REQ-018 Load (flush=0, stall=0): latch valid_in, instruction_in, alu_result_in, mem_data_in and pc_plus_one_in; one-cycle latency to outputs.
REQ-019 Stall (flush=0, stall=1): all latched registers and retire_count hold their values.
REQ-020 Flush=1: instruction register loads 32'h0 and the valid register loads 0, regardless of stall; the data registers are don't-care.
REQ-021 Opcodes are decoded from latched instruction[31:27]: ALU 00000, ADDI 00101, LW 01000, JAL 00011; all other opcodes are non-writing.
REQ-022 wb_dest: 5'd31 for JAL; otherwise latched instruction[26:22].
REQ-023 wb_data: latched mem_data for LW; latched pc_plus_one for JAL; latched alu_result for all other opcodes.
REQ-024 wb_enable = valid_out AND writing opcode AND (wb_dest != 0); it is combinational from latched state.
REQ-025 retire_count increments by 1 at every rising edge where valid_out=1 and stall=0.
REQ-026 retire_count wraps modulo 2^RETIRE_W with no saturation.
REQ-027 A flush in the same cycle as a retirement still counts the retiring instruction, because retirement is measured on the outgoing contents.
REQ-028 The decode outputs (wb_enable, wb_dest, wb_data) introduce no extra latency and depend only on latched state.

Reset
REQ-029 While reset=0, all registers clear asynchronously: instruction_out=0, valid_out=0, latched data=0, retire_count=0.
REQ-030 Consequently wb_enable=0, wb_dest=0 and wb_data=0 while reset=0.
REQ-031 After reset deasserts, the first load occurs on the next rising edge.
REQ-032 Reset asserted mid-stall or mid-flush overrides both immediately.

Structure
REQ-033 Opcode constants (ALU, ADDI, LW, JAL), the link register index 31 and the field bit positions belong in the shared processor package.
REQ-034 The combinational decode SHALL be a sub-module wb_decode (input instruction, output is_write, is_lw, is_jal).
REQ-035 The pipeline registers and retire counter reside in mem_wb_latch.

Verification
REQ-036 Load ADDI r5, alu_result=32'h0000_0007, valid_in=1 -> next cycle: wb_enable=1, wb_dest=5, wb_data=7, retire_count 0->1 on the following edge.
REQ-037 Load LW r3, mem_data=32'hDEAD_BEEF, alu_result=32'h10 -> wb_data=32'hDEAD_BEEF, wb_dest=3, wb_enable=1.
REQ-038 Load JAL, pc_plus_one=32'h40 -> wb_dest=31, wb_data=32'h40, wb_enable=1.
REQ-039 Load ALU op with rd=0, then load SW (opcode 00111) -> wb_enable=0 in both cycles; retire_count still increments twice.
REQ-040 Latch ADDI r2, then assert stall=1 for 3 cycles with changing inputs -> outputs unchanged and retire_count frozen; then assert flush=1 with stall=1 -> valid_out=0, instruction_out=0.
REQ-041 Preload retire_count to all-ones via 2^RETIRE_W-1 retirements (or RETIRE_W=4 with 15), retire one more -> wraps to 0; then assert reset=0 mid-cycle -> all outputs 0 without waiting for a clock edge.
